// File: rtl/pic_pkg.sv
// Shared types and helpers for the PIC interrupt request register.
// Holds the acknowledge FSM state type and the priority search function.
package pic_pkg;

    // Widest channel count any PIC block in this slice supports.
    localparam int MAX_IRQ = 32;

    // Default channel count and the index reported on a spurious acknowledge.
    localparam int DEF_NUM_IRQ  = 8;
    localparam int SPURIOUS_IDX = DEF_NUM_IRQ - 1;

    // Acknowledge handshake: IDLE waits for the first INTA, ACK1 for the second.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK1 = 1'b1
    } ack_state_t;

    // Result of a priority search over a request vector.
    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } prio_t;

    // Lowest set index wins; found=0 when the vector is empty.
    function automatic prio_t prio_first(input logic [MAX_IRQ-1:0] vec);
        prio_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = MAX_IRQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.idx   = 5'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_line_sync.sv
// Two-flop synchronizer bank for asynchronous IR request pins.
// Used only when IRQ_SYNC_EN is defined.
module irq_line_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two back-to-back flops; both clear to 0 on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/irq_request_latch.sv
// Interrupt request register with masking, priority select and INTA handshake.
// Define IRQ_SYNC_EN to pass irq_lines through a 2-flop synchronizer first.
module irq_request_latch
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_lines,
    input  logic [NUM_IRQ-1:0] trig_level,
    input  logic [NUM_IRQ-1:0] imr,
    input  logic               inta,
    output logic [NUM_IRQ-1:0] irr,
    output logic               int_req,
    output logic [IDX_W-1:0]   ack_idx,
    output logic               ack_spurious,
    output logic               ack_valid
);

    localparam int SPUR_IDX = NUM_IRQ - 1;

    logic [NUM_IRQ-1:0] line;
    logic [NUM_IRQ-1:0] prev_line;
    logic [NUM_IRQ-1:0] cand;
    logic [NUM_IRQ-1:0] clr_mask;
    logic [NUM_IRQ-1:0] irr_n;
    ack_state_t         state;
    ack_state_t         state_n;
    prio_t              pf;
    logic               first_ack;
    logic               second_ack;

`ifdef IRQ_SYNC_EN
    irq_line_sync #(
        .W (NUM_IRQ)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (irq_lines),
        .q     (line)
    );
`else
    assign line = irq_lines;
`endif

    // Pick the highest-priority unmasked pending request.
    always_comb begin
        cand = irr & ~imr;
        pf   = prio_first(MAX_IRQ'(cand));
    end

    // Handshake step decode and next state.
    always_comb begin
        state_n    = state;
        first_ack  = 1'b0;
        second_ack = 1'b0;
        unique case (state)
            IDLE: begin
                if (inta) begin
                    first_ack = 1'b1;
                    state_n   = ACK1;
                end
            end
            ACK1: begin
                if (inta) begin
                    second_ack = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Next request bits: edge/level capture, then the acknowledge clear on top.
    always_comb begin
        clr_mask = '0;
        irr_n    = irr;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr_mask[i] = first_ack && pf.found && (pf.idx == 5'(i));
            if (trig_level[i]) begin
                irr_n[i] = line[i];
            end else if (line[i] && !prev_line[i]) begin
                irr_n[i] = 1'b1;
            end else if (!line[i]) begin
                irr_n[i] = 1'b0;
            end
            if (clr_mask[i]) begin
                irr_n[i] = 1'b0;
            end
        end
    end

    // FSM state register; reset aborts any handshake in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Request bits and line history; history resets high so held lines are not edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            irr       <= '0;
            prev_line <= '1;
        end else begin
            irr       <= irr_n;
            prev_line <= line;
        end
    end

    // Registered CPU-facing outputs and the captured acknowledge result.
    always_ff @(posedge clk) begin
        if (reset) begin
            int_req      <= 1'b0;
            ack_idx      <= '0;
            ack_spurious <= 1'b0;
            ack_valid    <= 1'b0;
        end else begin
            int_req   <= (state_n == IDLE) && (|cand);
            ack_valid <= second_ack;
            if (first_ack) begin
                if (pf.found) begin
                    ack_idx      <= IDX_W'(pf.idx);
                    ack_spurious <= 1'b0;
                end else begin
                    ack_idx      <= IDX_W'(SPUR_IDX);
                    ack_spurious <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed-vector bench for irq_request_latch (8 channels) plus a
// 16-channel instance for the spurious index width case.
module tb_irq_request_latch;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_lines;
    logic [7:0] trig_level;
    logic [7:0] imr;
    logic       inta;
    logic [7:0] irr;
    logic       int_req;
    logic [2:0] ack_idx;
    logic       ack_spurious;
    logic       ack_valid;

    logic [15:0] irq16;
    logic [15:0] trig16;
    logic [15:0] imr16;
    logic        inta16;
    logic [15:0] irr16;
    logic        int16;
    logic [3:0]  idx16;
    logic        sp16;
    logic        av16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_request_latch #(.NUM_IRQ(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .irq_lines    (irq_lines),
        .trig_level   (trig_level),
        .imr          (imr),
        .inta         (inta),
        .irr          (irr),
        .int_req      (int_req),
        .ack_idx      (ack_idx),
        .ack_spurious (ack_spurious),
        .ack_valid    (ack_valid)
    );

    irq_request_latch #(.NUM_IRQ(16)) dut16 (
        .clk          (clk),
        .reset        (reset),
        .irq_lines    (irq16),
        .trig_level   (trig16),
        .imr          (imr16),
        .inta         (inta16),
        .irr          (irr16),
        .int_req      (int16),
        .ack_idx      (idx16),
        .ack_spurious (sp16),
        .ack_valid    (av16)
    );

    typedef struct {
        logic [7:0] lines;
        logic [7:0] trig;
        logic [7:0] mask;
        logic       ack;
        logic [7:0] e_irr;
        logic       e_int;
        logic       e_av;
        logic [2:0] e_idx;
        logic       e_sp;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic [7:0] l, input logic [7:0] t,
                       input logic [7:0] m, input logic a,
                       input logic [7:0] ei, input logic en,
                       input logic ev, input logic [2:0] ex,
                       input logic es);
        vec_t v;
        v.lines = l; v.trig = t; v.mask = m; v.ack = a;
        v.e_irr = ei; v.e_int = en; v.e_av = ev;
        v.e_idx = ex; v.e_sp = es;
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic [7:0] ei,
                           input logic en, input logic ev,
                           input logic [2:0] ex, input logic es);
        chk({nm, ".irr"}, 32'(irr), 32'(ei));
        chk({nm, ".int_req"}, 32'(int_req), 32'(en));
        chk({nm, ".ack_valid"}, 32'(ack_valid), 32'(ev));
        chk({nm, ".ack_idx"}, 32'(ack_idx), 32'(ex));
        chk({nm, ".ack_spurious"}, 32'(ack_spurious), 32'(es));
    endtask

    initial begin
        reset = 1'b1;
        irq_lines = '0; trig_level = '0; imr = '0; inta = 1'b0;
        irq16 = '0; trig16 = '0; imr16 = '0; inta16 = 1'b0;

        //  lines trig  mask  ack  irr  int av idx sp
        // edge IR3 request, handshake, re-request
        add(8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 3'd0, 0);
        add(8'h08, 8'h00, 8'h00, 0, 8'h08, 0, 0, 3'd0, 0);
        add(8'h08, 8'h00, 8'h00, 0, 8'h08, 1, 0, 3'd0, 0);
        add(8'h08, 8'h00, 8'h00, 1, 8'h00, 0, 0, 3'd3, 0);
        add(8'h08, 8'h00, 8'h00, 0, 8'h00, 0, 0, 3'd3, 0);
        add(8'h08, 8'h00, 8'h00, 1, 8'h00, 0, 1, 3'd3, 0);
        add(8'h08, 8'h00, 8'h00, 0, 8'h00, 0, 0, 3'd3, 0);
        add(8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 3'd3, 0);
        add(8'h08, 8'h00, 8'h00, 0, 8'h08, 0, 0, 3'd3, 0);
        add(8'h08, 8'h00, 8'h00, 0, 8'h08, 1, 0, 3'd3, 0);
        add(8'h00, 8'h00, 8'h00, 0, 8'h00, 1, 0, 3'd3, 0);
        add(8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 3'd3, 0);
        // level ch5 + edge IR2: 2 wins, then 5, then 5 reloads
        add(8'h24, 8'h20, 8'h00, 0, 8'h24, 0, 0, 3'd3, 0);
        add(8'h24, 8'h20, 8'h00, 1, 8'h20, 0, 0, 3'd2, 0);
        add(8'h24, 8'h20, 8'h00, 1, 8'h20, 1, 1, 3'd2, 0);
        add(8'h24, 8'h20, 8'h00, 1, 8'h00, 0, 0, 3'd5, 0);
        add(8'h24, 8'h20, 8'h00, 0, 8'h20, 0, 0, 3'd5, 0);
        add(8'h24, 8'h20, 8'h00, 1, 8'h20, 1, 1, 3'd5, 0);
        add(8'h00, 8'h20, 8'h00, 0, 8'h00, 1, 0, 3'd5, 0);
        add(8'h00, 8'h20, 8'h00, 0, 8'h00, 0, 0, 3'd5, 0);
        // fully masked IR0, then unmask
        add(8'h01, 8'h00, 8'hFF, 0, 8'h01, 0, 0, 3'd5, 0);
        add(8'h01, 8'h00, 8'hFF, 0, 8'h01, 0, 0, 3'd5, 0);
        add(8'h01, 8'h00, 8'h00, 0, 8'h01, 1, 0, 3'd5, 0);
        // IR1 edge drops before inta -> spurious
        add(8'h02, 8'h00, 8'h00, 0, 8'h02, 1, 0, 3'd5, 0);
        add(8'h00, 8'h00, 8'h00, 0, 8'h00, 1, 0, 3'd5, 0);
        add(8'h00, 8'h00, 8'h00, 1, 8'h00, 0, 0, 3'd7, 1);
        add(8'h00, 8'h00, 8'h00, 1, 8'h00, 0, 1, 3'd7, 1);
        // masked pending bit is neither selected nor cleared
        add(8'h04, 8'h00, 8'h04, 0, 8'h04, 0, 0, 3'd7, 1);
        add(8'h04, 8'h00, 8'h04, 1, 8'h04, 0, 0, 3'd7, 1);
        add(8'h04, 8'h00, 8'h04, 1, 8'h04, 0, 1, 3'd7, 1);
        add(8'h04, 8'h00, 8'h00, 0, 8'h04, 1, 0, 3'd7, 1);
        // masked IR2 pending, IR4 selected past it
        add(8'h14, 8'h00, 8'h04, 0, 8'h14, 0, 0, 3'd7, 1);
        add(8'h14, 8'h00, 8'h04, 1, 8'h04, 0, 0, 3'd4, 0);
        add(8'h14, 8'h00, 8'h04, 1, 8'h04, 0, 1, 3'd4, 0);
        add(8'h14, 8'h00, 8'h00, 0, 8'h04, 1, 0, 3'd4, 0);

        step();
        step();
        chk_all("reset", 8'h00, 0, 0, 3'd0, 0);
        chk("reset16.irr", 32'(irr16), 32'h0);
        chk("reset16.idx", 32'(idx16), 32'h0);
        reset = 1'b0;

        for (int k = 0; k < tv.size(); k++) begin
            irq_lines  = tv[k].lines;
            trig_level = tv[k].trig;
            imr        = tv[k].mask;
            inta       = tv[k].ack;
            step();
            chk_all($sformatf("vec%0d", k), tv[k].e_irr, tv[k].e_int,
                    tv[k].e_av, tv[k].e_idx, tv[k].e_sp);
        end

        // reset between the two intas aborts the handshake
        irq_lines = 8'h00; trig_level = 8'h00; imr = 8'h00; inta = 1'b0;
        step();
        step();
        irq_lines = 8'h40;
        step();
        chk("rst_ack.irr_set", 32'(irr), 32'h40);
        inta = 1'b1;
        step();
        chk("rst_ack.first_idx", 32'(ack_idx), 32'd6);
        chk("rst_ack.first_irr", 32'(irr), 32'h00);
        reset = 1'b1;
        step();
        chk_all("rst_ack.in_reset", 8'h00, 0, 0, 3'd0, 0);
        reset = 1'b0;
        inta = 1'b0;
        step();
        chk_all("rst_ack.after1", 8'h00, 0, 0, 3'd0, 0);
        step();
        chk_all("rst_ack.after2", 8'h00, 0, 0, 3'd0, 0);
        inta = 1'b1;
        step();
        chk_all("rst_ack.new_first", 8'h00, 0, 0, 3'd7, 1);
        inta = 1'b0;
        step();
        inta = 1'b1;
        step();
        chk_all("rst_ack.new_second", 8'h00, 0, 1, 3'd7, 1);
        inta = 1'b0;
        step();
        chk("rst_ack.av_drop", 32'(ack_valid), 32'h0);

        // 16 channels: spurious index is 15
        inta16 = 1'b1;
        step();
        chk("n16.first_sp", 32'(sp16), 32'h1);
        chk("n16.first_av", 32'(av16), 32'h0);
        inta16 = 1'b0;
        step();
        inta16 = 1'b1;
        step();
        chk("n16.idx", 32'(idx16), 32'd15);
        chk("n16.sp", 32'(sp16), 32'h1);
        chk("n16.av", 32'(av16), 32'h1);
        chk("n16.int", 32'(int16), 32'h0);
        inta16 = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
